// File: rtl/axi_tlb_l1_mc.sv
// Multi-channel L1 translation table. Translates per-channel request addresses through one
// shared segment table, with a one-cycle result register per channel and a saturating miss counter.
module axi_tlb_l1_mc #(
    parameter int NumChannels     = 2,
    parameter int NumEntries      = 4,
    parameter int InpAddrWidth    = 32,
    parameter int OupAddrWidth    = 32,
    parameter int PageOffsetWidth = 12,
    parameter int CntWidth        = 16,
    localparam int IPW = InpAddrWidth - PageOffsetWidth,
    localparam int OPW = OupAddrWidth - PageOffsetWidth,
    localparam int IW  = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumChannels*InpAddrWidth-1:0]  req_addr_i,
    input  logic [NumChannels-1:0]               req_write_i,
    input  logic [NumChannels-1:0]               req_valid_i,
    output logic [NumChannels-1:0]               req_ready_o,
    output logic [NumChannels*OupAddrWidth-1:0]  res_addr_o,
    output logic [NumChannels-1:0]               res_hit_o,
    output logic [NumChannels-1:0]               res_valid_o,
    input  logic [NumChannels-1:0]               res_ready_i,
    input  logic                                 cfg_we_i,
    input  logic [IW-1:0]                        cfg_idx_i,
    input  logic [IPW-1:0]                       cfg_first_i,
    input  logic [IPW-1:0]                       cfg_last_i,
    input  logic [OPW-1:0]                       cfg_base_i,
    input  logic [2:0]                           cfg_flags_i,
    output logic [CntWidth-1:0]                  miss_cnt_o,
    input  logic                                 miss_cnt_clr_i
);

    // Page arithmetic is done at the wider of the two page widths so the low OPW bits wrap correctly.
    localparam int MW = (IPW > OPW) ? IPW : OPW;
    localparam int SW = CntWidth + $clog2(NumChannels + 1);
    localparam logic [SW-1:0] CntMax = SW'({CntWidth{1'b1}});

    logic [IPW-1:0] r_first [NumEntries];
    logic [IPW-1:0] r_last  [NumEntries];
    logic [OPW-1:0] r_base  [NumEntries];
    logic [2:0]     r_flags [NumEntries];

    logic [NumChannels-1:0] w_miss;
    logic [SW-1:0]          w_miss_num;
    logic [SW-1:0]          w_sum;
    logic [CntWidth-1:0]    r_miss_cnt;
    logic [CntWidth-1:0]    w_miss_cnt_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumEntries; i++) begin
                r_first[i] <= '0;
                r_last[i]  <= '0;
                r_base[i]  <= '0;
                r_flags[i] <= '0;
            end
        end else if (cfg_we_i && (32'(cfg_idx_i) < 32'(NumEntries))) begin
            r_first[cfg_idx_i] <= cfg_first_i;
            r_last[cfg_idx_i]  <= cfg_last_i;
            r_base[cfg_idx_i]  <= cfg_base_i;
            r_flags[cfg_idx_i] <= cfg_flags_i;
        end
    end

    for (genvar gi = 0; gi < NumChannels; gi++) begin : g_ch
        logic [IPW-1:0]             w_page;
        logic [PageOffsetWidth-1:0] w_off;
        logic                       w_hit;
        logic [OPW-1:0]             w_opage;
        logic                       w_accept;
        logic                       r_res_valid;
        logic                       r_res_hit;
        logic [OupAddrWidth-1:0]    r_res_addr;

        assign w_page = req_addr_i[gi*InpAddrWidth+PageOffsetWidth +: IPW];
        assign w_off  = req_addr_i[gi*InpAddrWidth +: PageOffsetWidth];

        // Scan from the highest index down so the lowest matching entry is the one that sticks.
        always_comb begin
            w_hit   = 1'b0;
            w_opage = '0;
            for (int i = NumEntries - 1; i >= 0; i--) begin
                if (r_flags[i][0] &&
                    (req_write_i[gi] ? r_flags[i][2] : r_flags[i][1]) &&
                    (w_page >= r_first[i]) && (w_page <= r_last[i])) begin
                    w_hit   = 1'b1;
                    w_opage = OPW'(MW'(w_page) - MW'(r_first[i]) + MW'(r_base[i]));
                end
            end
        end

        assign req_ready_o[gi] = !r_res_valid || res_ready_i[gi];
        assign w_accept        = req_valid_i[gi] && req_ready_o[gi];
        assign w_miss[gi]      = w_accept && !w_hit;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_res_valid <= 1'b0;
                r_res_hit   <= 1'b0;
                r_res_addr  <= '0;
            end else if (w_accept) begin
                r_res_valid <= 1'b1;
                r_res_hit   <= w_hit;
                r_res_addr  <= w_hit ? {w_opage, w_off} : '0;
            end else if (res_ready_i[gi]) begin
                r_res_valid <= 1'b0;
            end
        end

        assign res_valid_o[gi]                              = r_res_valid;
        assign res_hit_o[gi]                                = r_res_hit;
        assign res_addr_o[gi*OupAddrWidth +: OupAddrWidth] = r_res_addr;
    end

    always_comb begin
        w_miss_num = '0;
        for (int c = 0; c < NumChannels; c++) begin
            w_miss_num = w_miss_num + SW'(w_miss[c]);
        end
        w_sum = SW'(r_miss_cnt) + w_miss_num;
        if (miss_cnt_clr_i) begin
            w_miss_cnt_next = '0;
        end else if (w_sum > CntMax) begin
            w_miss_cnt_next = {CntWidth{1'b1}};
        end else begin
            w_miss_cnt_next = w_sum[CntWidth-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_miss_cnt <= '0;
        end else begin
            r_miss_cnt <= w_miss_cnt_next;
        end
    end

    assign miss_cnt_o = r_miss_cnt;

endmodule

// File: tb/tb_axi_tlb_l1_mc.sv
// Randomised and directed bench for axi_tlb_l1_mc against a first-match reference model.
module tb_axi_tlb_l1_mc;
    localparam int NCH = 2;
    localparam int NENT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] req_addr;
    logic [1:0]  req_write, req_valid, res_ready;
    logic [1:0]  req_ready, res_hit, res_valid;
    logic [63:0] res_addr;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [19:0] cfg_first, cfg_last, cfg_base;
    logic [2:0]  cfg_flags;
    logic [3:0]  miss_cnt;
    logic        clr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int unsigned m_first [NENT];
    int unsigned m_last  [NENT];
    int unsigned m_base  [NENT];
    logic [2:0]  m_flags [NENT];
    logic        m_pend  [NCH];
    logic [31:0] m_addr  [NCH];
    logic        m_hit   [NCH];
    int          m_cnt;

    axi_tlb_l1_mc #(
        .NumChannels(NCH), .NumEntries(NENT), .InpAddrWidth(32), .OupAddrWidth(32),
        .PageOffsetWidth(12), .CntWidth(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_addr_i(req_addr), .req_write_i(req_write), .req_valid_i(req_valid),
        .req_ready_o(req_ready), .res_addr_o(res_addr), .res_hit_o(res_hit),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_first_i(cfg_first), .cfg_last_i(cfg_last),
        .cfg_base_i(cfg_base), .cfg_flags_i(cfg_flags),
        .miss_cnt_o(miss_cnt), .miss_cnt_clr_i(clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_lookup(input logic [31:0] addr, input logic wr,
                                         output logic [31:0] oaddr, output logic hit);
        int unsigned page;
        page  = addr >> 12;
        hit   = 1'b0;
        oaddr = '0;
        for (int e = 0; e < NENT; e++) begin
            if (m_flags[e][0] && (wr ? m_flags[e][2] : m_flags[e][1]) &&
                page >= m_first[e] && page <= m_last[e]) begin
                hit   = 1'b1;
                oaddr = (((page - m_first[e] + m_base[e]) % (1 << 20)) << 12) | (addr & 32'hFFF);
                break;
            end
        end
    endfunction

    task automatic model_reset();
        for (int e = 0; e < NENT; e++) begin
            m_first[e] = 0; m_last[e] = 0; m_base[e] = 0; m_flags[e] = 3'b000;
        end
        for (int c = 0; c < NCH; c++) begin
            m_pend[c] = 1'b0; m_addr[c] = '0; m_hit[c] = 1'b0;
        end
        m_cnt = 0;
    endtask

    task automatic idle();
        req_addr = '0; req_write = '0; req_valid = '0; res_ready = 2'b11;
        cfg_we = 1'b0; cfg_idx = '0; cfg_first = '0; cfg_last = '0; cfg_base = '0;
        cfg_flags = '0; clr = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] idx, input logic [19:0] f, input logic [19:0] l,
                           input logic [19:0] b, input logic [2:0] fl);
        cfg_we = 1'b1; cfg_idx = idx; cfg_first = f; cfg_last = l; cfg_base = b; cfg_flags = fl;
    endtask

    task automatic req(input int c, input logic [31:0] a, input logic wr);
        req_valid[c] = 1'b1;
        req_write[c] = wr;
        req_addr[c*32 +: 32] = a;
    endtask

    // One clock of stimulus: predict handshakes and results, clock the DUT, then compare.
    task automatic step();
        logic        acc [NCH];
        logic [31:0] na  [NCH];
        logic        nh  [NCH];
        logic        exp_rdy;
        int          misses;
        misses = 0;
        #1;
        for (int c = 0; c < NCH; c++) begin
            exp_rdy = !m_pend[c] || res_ready[c];
            check($sformatf("req_ready%0d", c), 32'(req_ready[c]), 32'(exp_rdy));
            acc[c] = req_valid[c] && exp_rdy;
            na[c] = '0;
            nh[c] = 1'b0;
            if (acc[c]) begin
                model_lookup(req_addr[c*32 +: 32], req_write[c], na[c], nh[c]);
                if (!nh[c]) misses++;
                $display("t=%0t ch%0d addr=%h wr=%b -> exp addr=%h hit=%b",
                         $time, c, req_addr[c*32 +: 32], req_write[c], na[c], nh[c]);
            end
        end
        @(posedge clk);
        #1;
        if (cfg_we && cfg_idx < NENT) begin
            m_first[cfg_idx] = cfg_first;
            m_last[cfg_idx]  = cfg_last;
            m_base[cfg_idx]  = cfg_base;
            m_flags[cfg_idx] = cfg_flags;
        end
        if (clr) m_cnt = 0;
        else     m_cnt = (m_cnt + misses > 15) ? 15 : m_cnt + misses;
        for (int c = 0; c < NCH; c++) begin
            if (acc[c]) begin
                m_pend[c] = 1'b1; m_addr[c] = na[c]; m_hit[c] = nh[c];
            end else if (res_ready[c]) begin
                m_pend[c] = 1'b0;
            end
            check($sformatf("res_valid%0d", c), 32'(res_valid[c]), 32'(m_pend[c]));
            if (m_pend[c]) begin
                check($sformatf("res_addr%0d", c), res_addr[c*32 +: 32], m_addr[c]);
                check($sformatf("res_hit%0d", c), 32'(res_hit[c]), 32'(m_hit[c]));
            end
        end
        check("miss_cnt", 32'(miss_cnt), 32'(m_cnt));
    endtask

    task automatic do_reset();
        idle();
        res_ready = 2'b00;
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_hit", 32'(res_hit), 32'd0);
        check("rst_addr", res_addr[31:0], 32'd0);
        check("rst_cnt", 32'(miss_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        model_reset();
        do_reset();

        // Basic hit
        set_cfg(2'd0, 20'h10, 20'h1F, 20'h80, 3'b011); step();
        idle(); req(0, 32'h0001_2ABC, 1'b0); step();
        check("basic_addr", res_addr[31:0], 32'h0008_2ABC);
        check("basic_hit", 32'(res_hit[0]), 32'd1);

        // Write permission miss
        idle(); req(1, 32'h0001_2000, 1'b1); step();
        check("perm_hit", 32'(res_hit[1]), 32'd0);
        check("perm_addr", res_addr[63:32], 32'd0);
        check("perm_cnt", 32'(miss_cnt), 32'd1);

        // Lowest index wins among overlapping writable entries
        idle(); set_cfg(2'd1, 20'h00, 20'hFF, 20'h200, 3'b101); step();
        idle(); set_cfg(2'd2, 20'h10, 20'h20, 20'h300, 3'b101); step();
        idle(); req(1, 32'h0001_2345, 1'b1); step();
        check("prio_addr", res_addr[63:32], 32'h0021_2345);

        // Backpressure with table rewrites while held
        idle(); req(0, 32'h0001_2ABC, 1'b0); step();
        for (int k = 0; k < 5; k++) begin
            idle();
            res_ready[0] = 1'b0;
            req(0, 32'h0001_5000, 1'b0);
            req(1, 32'h0001_2000 + 32'(k), 1'b0);
            set_cfg(2'd0, 20'h10, 20'h1F, 20'h40 + 20'(k), 3'b011);
            step();
            check("bp_ready", 32'(req_ready[0]), 32'd0);
            check("bp_addr", res_addr[31:0], 32'h0008_2ABC);
            check("bp_ch1_valid", 32'(res_valid[1]), 32'd1);
        end
        idle(); step();

        // Same-cycle write and lookup uses the old entry
        idle(); set_cfg(2'd0, 20'h10, 20'h1F, 20'h80, 3'b011); step();
        idle(); set_cfg(2'd0, 20'h10, 20'h1F, 20'h90, 3'b011); req(0, 32'h0001_2ABC, 1'b0); step();
        check("sim_old", res_addr[31:0], 32'h0008_2ABC);
        idle(); req(0, 32'h0001_2ABC, 1'b0); step();
        check("sim_new", res_addr[31:0], 32'h0009_2ABC);

        // Clear beats two simultaneous misses
        idle(); req(0, 32'h0050_0000, 1'b0); req(1, 32'h0050_0000, 1'b0); clr = 1'b1; step();
        check("clr_cnt", 32'(miss_cnt), 32'd0);

        // Saturation after 20 misses
        for (int k = 0; k < 10; k++) begin
            idle(); req(0, 32'h0050_0000, 1'b0); req(1, 32'h0060_0000, 1'b1); step();
        end
        check("sat_cnt", 32'(miss_cnt), 32'd15);

        // Output page wraps
        idle(); set_cfg(2'd0, 20'h10, 20'h1F, 20'hFFFFF, 3'b011); step();
        idle(); req(0, 32'h0001_2345, 1'b0); step();
        check("wrap_addr", res_addr[31:0], 32'h0000_1345);

        // Reset while results are held
        idle(); req(0, 32'h0001_2345, 1'b0); req(1, 32'h0001_2345, 1'b1); step();
        do_reset();
        idle(); req(0, 32'h0001_2345, 1'b0); step();
        check("post_rst_hit", 32'(res_hit[0]), 32'd0);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int c = 0; c < NCH; c++) begin
                res_ready[c] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 1) begin
                    req(c, (32'($urandom_range(0, 32'h3F)) << 12) | (32'($urandom) & 32'hFFF),
                        1'($urandom_range(0, 1)));
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                cfg_we    = 1'b1;
                cfg_idx   = 2'($urandom_range(0, 3));
                cfg_first = 20'($urandom_range(0, 32'h30));
                cfg_last  = cfg_first + 20'($urandom_range(0, 32'h20));
                if ($urandom_range(0, 7) == 0) cfg_last = 20'($urandom_range(0, 32'h3F));
                cfg_base  = 20'($urandom);
                cfg_flags = 3'($urandom_range(0, 7));
            end
            clr = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
